// File: rtl/branch_predictor_btb.sv
// rtl/branch_predictor_btb.sv - direct-mapped branch target buffer with 2-bit counters
//
// Purpose: zero-latency lookup of a predicted next fetch PC, trained by resolved
// beq/bne branches from EX. Also reports a registered mispredict pulse and
// saturating branch / mispredict statistics.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   fetch_pc                   PC looked up this cycle (combinational)
//   pred_hit/taken/target      lookup results
//   upd_valid, upd_pc,
//   upd_taken, upd_target      resolved branch outcome
//   upd_pred_taken/target      prediction that travelled with the branch
//   flush                      invalidate every entry at the next edge
//   mispredict                 one-cycle pulse after a mispredicted update
//   stat_branches/mispredicts  saturating event counters
module branch_predictor_btb #(
    parameter int ADDR_WIDTH   = 32,
    parameter int ENTRIES      = 16,
    parameter int PREDICT_MODE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] fetch_pc,
    output logic                  pred_hit,
    output logic                  pred_taken,
    output logic [ADDR_WIDTH-1:0] pred_target,
    input  logic                  upd_valid,
    input  logic [ADDR_WIDTH-1:0] upd_pc,
    input  logic                  upd_taken,
    input  logic [ADDR_WIDTH-1:0] upd_target,
    input  logic                  upd_pred_taken,
    input  logic [ADDR_WIDTH-1:0] upd_pred_target,
    input  logic                  flush,
    output logic                  mispredict,
    output logic [31:0]           stat_branches,
    output logic [31:0]           stat_mispredicts
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_WIDTH - IDX - 2;

    logic [ENTRIES-1:0]    valid_q, valid_d;
    logic [TAG_W-1:0]      tag_q    [ENTRIES];
    logic [TAG_W-1:0]      tag_d    [ENTRIES];
    logic [ADDR_WIDTH-1:0] target_q [ENTRIES];
    logic [ADDR_WIDTH-1:0] target_d [ENTRIES];
    logic [1:0]            ctr_q    [ENTRIES];
    logic [1:0]            ctr_d    [ENTRIES];

    logic        mispredict_q, mispredict_d;
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

    logic [IDX-1:0]   f_idx, u_idx;
    logic [TAG_W-1:0] f_tag, u_tag;
    logic             u_hit;
    logic             u_mispred;

    // Low PC bits are always zero for word-aligned branches and carry no information.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{fetch_pc[1:0], upd_pc[1:0]};

    assign f_idx = fetch_pc[IDX+1:2];
    assign f_tag = fetch_pc[ADDR_WIDTH-1:IDX+2];
    assign u_idx = upd_pc[IDX+1:2];
    assign u_tag = upd_pc[ADDR_WIDTH-1:IDX+2];

    // Lookup reads only registered state, so a same-cycle update is not visible.
    always_comb begin
        pred_hit   = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        pred_taken = 1'b0;
        if (PREDICT_MODE != 0) begin
            pred_taken = pred_hit && ctr_q[f_idx][1];
        end
        pred_target = pred_taken ? target_q[f_idx] : fetch_pc + ADDR_WIDTH'(4);
    end

    assign u_hit     = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign u_mispred = (upd_pred_taken != upd_taken) ||
                       (upd_taken && (upd_pred_target != upd_target));

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;

        // A flush takes precedence over training for the table contents.
        if (flush) begin
            valid_d = '0;
        end else if (upd_valid) begin
            if (u_hit) begin
                if (upd_taken) begin
                    if (ctr_q[u_idx] != 2'b11) begin
                        ctr_d[u_idx] = ctr_q[u_idx] + 2'b01;
                    end
                    target_d[u_idx] = upd_target;
                end else if (ctr_q[u_idx] != 2'b00) begin
                    ctr_d[u_idx] = ctr_q[u_idx] - 2'b01;
                end
            end else if (upd_taken) begin
                valid_d[u_idx]  = 1'b1;
                tag_d[u_idx]    = u_tag;
                target_d[u_idx] = upd_target;
                ctr_d[u_idx]    = 2'b10;
            end
        end

        // Statistics and the mispredict pulse still count updates that a flush suppressed.
        mispredict_d       = upd_valid && u_mispred;
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (upd_valid && (stat_branches_q != 32'hFFFF_FFFF)) begin
            stat_branches_d = stat_branches_q + 32'd1;
        end
        if (upd_valid && u_mispred && (stat_mispredicts_q != 32'hFFFF_FFFF)) begin
            stat_mispredicts_d = stat_mispredicts_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q            <= '0;
            mispredict_q       <= 1'b0;
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else begin
            valid_q            <= valid_d;
            tag_q              <= tag_d;
            target_q           <= target_d;
            ctr_q              <= ctr_d;
            mispredict_q       <= mispredict_d;
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign mispredict       = mispredict_q;
    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;

endmodule

// File: doc/branch_predictor_btb.md
BRANCH_PREDICTOR_BTB -- requirements
Module: branch_predictor_btb

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: PC and target width in bits.
REQ-002 Parameter ENTRIES, default 16: BTB depth; power of two, 2..256.
REQ-003 Parameter PREDICT_MODE, default 1: 0 = static not-taken (table still trained), 1 = 2-bit saturating counters.
REQ-004 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-006 Port fetch_pc  input  ADDR_WIDTH  PC being fetched this cycle, word-aligned.
REQ-007 Port pred_hit  output  1  fetch_pc matches a valid entry.
REQ-008 Port pred_taken  output  1  predict branch taken.
REQ-009 Port pred_target  output  ADDR_WIDTH  next fetch PC predicted.
REQ-010 Port upd_valid  input  1  a beq/bne resolved in EX this cycle.
REQ-011 Port upd_pc  input  ADDR_WIDTH  PC of the resolved branch.
REQ-012 Port upd_taken  input  1  actual branch outcome.
REQ-013 Port upd_target  input  ADDR_WIDTH  actual branch target.
REQ-014 Port upd_pred_taken  input  1  prediction carried down the pipe with the branch.
REQ-015 Port upd_pred_target  input  ADDR_WIDTH  predicted target carried down the pipe.
REQ-016 Port flush  input  1  invalidate all entries.
REQ-017 Port mispredict  output  1  registered; high one cycle after an update that mispredicted.
REQ-018 Port stat_branches  output  32  count of updates.
REQ-019 Port stat_mispredicts  output  32  count of mispredicted updates.

Function
REQ-020 Index = PC[IDX+1:2], tag = PC[ADDR_WIDTH-1:IDX+2], IDX = log2(ENTRIES); PC[1:0] ignored.
REQ-021 Entry state: valid bit, tag, target, 2-bit counter (00 strong NT, 01 weak NT, 10 weak T, 11 strong T).
REQ-022 Lookup combinational, zero latency: pred_hit = valid[idx] and tag match.
REQ-023 pred_taken = pred_hit and counter MSB in mode 1; pred_taken = 0 always in mode 0.
REQ-024 pred_target = stored target when pred_taken, else fetch_pc + 4 (wraps modulo 2^ADDR_WIDTH).
REQ-025 Update on upd_valid, hit on upd_pc: counter +1 if taken, -1 if not, saturating at 11/00; target overwritten with upd_target if taken.
REQ-026 Update on upd_valid, miss, upd_taken=1: allocate (overwrite) indexed entry: valid=1, tag, target=upd_target, counter=10.
REQ-027 Update on upd_valid, miss, upd_taken=0: no table change.
REQ-028 Misprediction = upd_pred_taken != upd_taken, or (upd_taken and upd_pred_target != upd_target).
REQ-029 mispredict asserted the cycle after a mispredicted update, for exactly one cycle per update.
REQ-030 stat_branches +1 per upd_valid; stat_mispredicts +1 per mispredicted update; both saturate at 32'hFFFFFFFF.
REQ-031 Same-cycle lookup and update on same index: lookup returns pre-update state (no bypass).
REQ-032 flush clears all valid bits at next edge; counters, targets, stats retained; flush with upd_valid same cycle: flush wins for table, stats and mispredict still count the update.
REQ-033 Back-to-back updates to same entry on consecutive cycles each apply in order.

Reset
REQ-034 On reset: all valid bits 0, all counters 01, targets 0, mispredict 0, stat_branches 0, stat_mispredicts 0.
REQ-035 Reset overrides flush and upd_valid in the same cycle; outputs reflect reset state the cycle after reset is sampled.
REQ-036 Reset mid-operation discards any pending update; no stat increment for that cycle.

Verification
REQ-037 After reset, fetch_pc=0x10 -> pred_hit=0, pred_taken=0, pred_target=0x14; stats 0.
REQ-038 Update pc=0x10 taken target=0x40, pred_taken=0 -> next cycle mispredict=1, stat_mispredicts=1; fetch 0x10 -> hit, taken, target 0x40.
REQ-039 Same entry: 3 not-taken updates -> counter 10->01->00->00; fetch 0x10 -> hit=1, taken=0, target 0x14.
REQ-040 ENTRIES=16: update taken pc=0x10 then pc=0x50 (same index, different tag) -> fetch 0x10 misses, 0x50 hits.
REQ-041 flush and upd_valid together -> all lookups miss next cycle, stat_branches still increments.
REQ-042 PREDICT_MODE=0: taken update pc=0x20 -> fetch 0x20 gives hit=1, pred_taken=0, target 0x24.
